fsm_slave_fifo: RTL

- Slave-side responder FSM for the master/slave serial link of the thermostat system, instantiated once in each house node (Manor, Cellar).
- Decodes request bytes from the local UART receiver.
- Write requests: accepts a new setpoint and acknowledges it.
- Read requests: streams the node's buffered temperature log, held in an internal FIFO, back through the local UART transmitter.
- This is the counterpart of the master FIFO FSM's write-request/write and read-request/read phases.

---
 rtl/fsm_slave_fifo.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fsm_slave_fifo.sv
// Slave link responder: WRITE latches a setpoint and acks, READ streams a snapshot of the sample log FIFO.
// tx_start follows its trigger by 1 cycle; the transmitter paces via tx_ready; full FIFO drops samples (sticky overflow).
module fsm_slave_fifo #(
  parameter int         DATA_W   = 8,
  parameter int         DEPTH    = 16,
  parameter logic [1:0] SLAVE_ID = 2'b01,
  parameter int         TIMEOUT  = 1000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_rx_valid,
  input  logic [DATA_W-1:0]        i_rx_data,
  input  logic                     i_tx_ready,
  output logic                     o_tx_start,
  output logic [DATA_W-1:0]        o_tx_data,
  input  logic                     i_sample_valid,
  input  logic [DATA_W-1:0]        i_sample_data,
  output logic [DATA_W-1:0]        o_setpoint,
  output logic                     o_setpoint_valid,
  output logic                     o_busy,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, SEND_ACK, SEND_HDR, SEND_DATA, WAIT_TX
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [TW-1:0]       r_tmo_cnt;
  logic [CW-1:0]       r_bytes_left;
  logic                r_is_read;
  logic [DATA_W-1:0]   r_tx_data;
  logic [DATA_W-1:0]   r_setpoint;
  logic                r_setpoint_vld;
  logic                r_overflow;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_count;

  logic                w_tx_start;
  logic [DATA_W-1:0]   w_tx_data;
  logic                w_pop, w_push, w_drop, w_full, w_id_ok, w_ovf_clr;

  assign w_id_ok   = (i_rx_data[7:6] == SLAVE_ID);
  assign w_full    = (r_count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a push against a full FIFO still lands.
  assign w_push    = i_sample_valid && (!w_full || w_pop);
  assign w_drop    = i_sample_valid && w_full && !w_pop;
  assign w_ovf_clr = (r_state == WAIT_TX) && i_tx_ready && (r_bytes_left == '0) && r_is_read;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_rx_valid && w_id_ok) begin
          if (i_rx_data[5:4] == 2'b01)      w_state_nxt = WAIT_DATA;
          else if (i_rx_data[5:4] == 2'b10) w_state_nxt = SEND_HDR;
        end
      end
      WAIT_DATA: begin
        if (i_rx_valid)                 w_state_nxt = SEND_ACK;
        else if (r_tmo_cnt == TMO_LAST) w_state_nxt = IDLE;
      end
      SEND_ACK, SEND_HDR, SEND_DATA: w_state_nxt = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_ready) w_state_nxt = (r_bytes_left != '0) ? SEND_DATA : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // tx_data is driven live in the SEND_* cycle and held from r_tx_data afterwards.
  always_comb begin
    w_tx_start = 1'b0;
    w_tx_data  = r_tx_data;
    w_pop      = 1'b0;
    case (r_state)
      SEND_ACK: begin
        w_tx_start = 1'b1;
        w_tx_data  = DATA_W'({SLAVE_ID, 6'b010000});
      end
      SEND_HDR: begin
        w_tx_start = 1'b1;
        w_tx_data  = DATA_W'({3'b101, r_count});
      end
      SEND_DATA: begin
        w_tx_start = 1'b1;
        w_tx_data  = r_mem[r_rd_ptr];
        w_pop      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tmo_cnt      <= '0;
      r_bytes_left   <= '0;
      r_is_read      <= 1'b0;
      r_tx_data      <= '0;
      r_setpoint     <= '0;
      r_setpoint_vld <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_tx_data      <= w_tx_data;
      r_setpoint_vld <= 1'b0;
      if (r_state == IDLE)      r_tmo_cnt <= '0;
      if (r_state == WAIT_DATA) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
        if (i_rx_valid) begin
          r_setpoint     <= i_rx_data;
          r_setpoint_vld <= 1'b1;
        end
      end
      if (r_state == SEND_ACK) begin
        r_bytes_left <= '0;
        r_is_read    <= 1'b0;
      end
      if (r_state == SEND_HDR) begin
        r_bytes_left <= r_count;
        r_is_read    <= 1'b1;
      end
      if (r_state == SEND_DATA) r_bytes_left <= r_bytes_left - CW'(1);
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_sample_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  assign o_tx_start       = w_tx_start;
  assign o_tx_data        = w_tx_data;
  assign o_setpoint       = r_setpoint;
  assign o_setpoint_valid = r_setpoint_vld;
  assign o_busy           = (r_state != IDLE);
  assign o_overflow       = r_overflow;
  assign o_fifo_count     = r_count;
endmodule
